// File: rtl/mcm_const_divider.sv
// rtl/mcm_const_divider.sv - restoring shift-subtract divider by three fixed constants in parallel
module mcm_const_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned D0    = 9,
  parameter int unsigned D1    = 23,
  parameter int unsigned D2    = 81
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] r2
);

  if (D0 == 0 || D1 == 0 || D2 == 0) begin : g_zero_divisor
    $error("mcm_const_divider: divisors must be nonzero");
  end
  if (64'(D0) >= (64'd1 << WIDTH) || 64'(D1) >= (64'd1 << WIDTH) ||
      64'(D2) >= (64'd1 << WIDTH)) begin : g_wide_divisor
    $error("mcm_const_divider: divisors must be below 2**WIDTH");
  end
  if (WIDTH < 2) begin : g_narrow
    $error("mcm_const_divider: WIDTH must be at least 2");
  end

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH+1:0] DV [3] = '{(WIDTH+2)'(D0), (WIDTH+2)'(D1), (WIDTH+2)'(D2)};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem     [3];
  logic [WIDTH-1:0] quo     [3];
  logic [WIDTH+1:0] trial   [3];
  logic [WIDTH:0]   rem_nxt [3];
  logic [2:0]       qbit;

  // One restoring step per divisor; rem < Dk keeps t - Dk within the remainder width.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      trial[k]   = {rem[k], shift[WIDTH-1]};
      qbit[k]    = (trial[k] >= DV[k]);
      rem_nxt[k] = qbit[k] ? (WIDTH+1)'(trial[k] - DV[k]) : (WIDTH+1)'(trial[k]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = BUSY;
      BUSY:    if (cnt == '0)     state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shift <= '0;
      cnt   <= '0;
      for (int k = 0; k < 3; k++) begin
        rem[k] <= '0;
        quo[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        shift <= x;
        cnt   <= CW'(WIDTH - 1);
        for (int k = 0; k < 3; k++) begin
          rem[k] <= '0;
          quo[k] <= '0;
        end
      end else if (state == BUSY) begin
        shift <= shift << 1;
        cnt   <= cnt - 1'b1;
        for (int k = 0; k < 3; k++) begin
          rem[k] <= rem_nxt[k];
          quo[k] <= {quo[k][WIDTH-2:0], qbit[k]};
        end
      end
    end
  end

  assign q0 = quo[0];
  assign q1 = quo[1];
  assign q2 = quo[2];
  assign r0 = rem[0][WIDTH-1:0];
  assign r1 = rem[1][WIDTH-1:0];
  assign r2 = rem[2][WIDTH-1:0];

endmodule

// File: tb/tb_mcm_const_divider.sv
// tb/tb_mcm_const_divider.sv - randomized bench for mcm_const_divider against a divide/modulo reference
module tb_mcm_const_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] x, q0, r0, q1, r1, q2, r2;

  int total = 0;
  int bad   = 0;
  longint unsigned divs [3] = '{9, 23, 81};

  mcm_const_divider #(.WIDTH(W), .D0(9), .D1(23), .D2(81)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready),
    .q0(q0), .r0(r0), .q1(q1), .r1(r1), .q2(q2), .r2(r2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned out_q(int k);
    return (k == 0) ? longint'(q0) : (k == 1) ? longint'(q1) : longint'(q2);
  endfunction

  function automatic longint unsigned out_r(int k);
    return (k == 0) ? longint'(r0) : (k == 1) ? longint'(r1) : longint'(r2);
  endfunction

  task automatic check_results(input string tag, input longint unsigned xv);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_q"}, out_q(k), xv / divs[k]);
      chk({tag, "_r"}, out_r(k), xv % divs[k]);
      chk({tag, "_recon"}, out_q(k) * divs[k] + out_r(k), xv);
      chk({tag, "_rlt"}, longint'(out_r(k) < divs[k]), 1);
    end
  endtask

  // Offer xv, wait for the result, optionally stall the consumer, then release it.
  task automatic do_op(input logic [W-1:0] xv, input int stall, output time t_acc);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", longint'(in_ready), 1);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    x         = xv;
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    in_valid = 1'b0;
    x        = $urandom;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      chk("in_ready_busy", longint'(in_ready), 0);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, W + 1);
    check_results("res", xv);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      x        = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", longint'(out_valid), 1);
      chk("stall_ready", longint'(in_ready), 0);
      check_results("stall", xv);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("valid_one_cycle", longint'(out_valid), 0);
    chk("ready_after", longint'(in_ready), 1);
    chk("retain_q0", longint'(q0), xv / 9);
  endtask

  initial begin
    time t1, t2, tdummy;
    logic [W-1:0] xr, prod;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    check_results("rst", 0);

    // Abort mid-BUSY with an asynchronous reset.
    in_valid = 1'b1;
    x        = 32'd12345;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", longint'(out_valid), 0);
    check_results("abort", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", longint'(in_ready), 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("no_spurious", longint'(out_valid), 0);
    end

    do_op(32'd100, 0, tdummy);
    chk("x100_q0", longint'(q0), 11);  chk("x100_r0", longint'(r0), 1);
    chk("x100_q1", longint'(q1), 4);   chk("x100_r1", longint'(r1), 8);
    chk("x100_q2", longint'(q2), 1);   chk("x100_r2", longint'(r2), 19);

    do_op(32'hFFFF_FFFF, 0, tdummy);
    chk("max_q0", longint'(q0), 477218588); chk("max_r0", longint'(r0), 3);
    chk("max_q1", longint'(q1), 186737708); chk("max_r1", longint'(r1), 11);
    chk("max_q2", longint'(q2), 53024287);  chk("max_r2", longint'(r2), 48);

    do_op(32'd81, 0, t1);
    chk("b81_q0", longint'(q0), 9); chk("b81_r1", longint'(r1), 12); chk("b81_q2", longint'(q2), 1);
    do_op(32'd0, 0, t2);
    chk("b2b_gap", longint'((t2 - t1) / 10 >= W + 2), 1);
    chk("zero_q1", longint'(q1), 0);

    do_op(32'd8, 10, tdummy);
    chk("x8_r2", longint'(r2), 8);

    for (int i = 0; i < 1000; i++) begin
      xr   = $urandom;
      prod = 32'(longint'(xr) * 9);
      do_op(prod, (i % 97 == 0) ? 3 : 0, tdummy);
      chk("rt_recon", longint'(q0) * 9 + longint'(r0), longint'(prod));
      if (longint'(xr) * 9 < 64'h1_0000_0000) chk("rt_q0", longint'(q0), longint'(xr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
